// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a show-ahead receive FIFO with sticky overrun/framing/parity flags.
module uart_rx_os #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     b_tick,
    input  logic                     rx,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     frame_err,
    output logic                     parity_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
`ifdef UART_RX_PARITY_EN
        , S_PAR
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; flops idle high so reset never looks like a start bit
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        push_req;
    logic        frame_set;
`ifdef UART_RX_PARITY_EN
    logic        par_pend_q, par_pend_d;
    logic        parity_set;
`endif

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            tick_q     <= 4'd0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_pend_q <= par_pend_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_pend_d = par_pend_q;
        parity_set = 1'b0;
`endif
        if (b_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        tick_d  = 4'd0;
                    end
                end
                S_START: begin
                    // Mid-start-bit recheck rejects glitches shorter than half a bit
                    if (tick_q == 4'd7) begin
                        tick_d = 4'd0;
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            bit_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                            par_pend_d = 1'b0;
`endif
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (tick_q == 4'd15) begin
                        shreg_d[bit_q] = rx_s_q;
                        tick_d         = 4'd0;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PAR;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PAR: begin
                    if (tick_q == 4'd15) begin
                        tick_d  = 4'd0;
                        state_d = S_STOP;
                        if (rx_s_q != ^shreg_q) begin
                            par_pend_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_q == 4'd15) begin
                        tick_d = 4'd0;
                        if (rx_s_q) begin
                            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_pend_q) begin
                                parity_set = 1'b1;
                            end else begin
                                push_req = 1'b1;
                            end
`else
                            push_req = 1'b1;
`endif
                        end else begin
                            frame_set = 1'b1;
                            state_d   = S_BRK;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                S_BRK: begin
                    // A held-low line must return high before a new start is accepted
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          do_push, do_pop, overrun_set;

    always_comb begin
        do_pop      = rd_en && !empty_q;
        // At full, a same-cycle pop frees the slot the push lands in
        do_push     = push_req && (!full_q || rd_en);
        overrun_set = push_req && full_q && !rd_en;
        wr_ptr_d    = wr_ptr_q + AW'(do_push);
        rd_ptr_d    = rd_ptr_q + AW'(do_pop);
        count_d     = count_q + CW'(do_push) - CW'(do_pop);
        rd_data_d   = rd_data_q;
        if (do_push && (count_q == CW'(do_pop))) begin
            rd_data_d = shreg_q;
        end else if (do_pop) begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            rd_data_q <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == CW'(DEPTH));
            rd_data_q <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a set event beats a same-cycle clear
    // ------------------------------------------------------------------
    logic overrun_q, frame_err_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= (overrun_q && !err_clr) || overrun_set;
            frame_err_q <= (frame_err_q && !err_clr) || frame_set;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= (parity_err_q && !err_clr) || parity_set;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rd_data   = rd_data_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: random and directed frames checked against a byte-queue model.
module tb_uart_rx_os;

    localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // clk edges from the edge that launches the start bit to the stop-sample edge
    localparam int STOP_CLK = PAR_EN ? 171 : 155;

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       b_tick = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [3:0] count;
    logic       overrun, frame_err, parity_err;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted bytes in arrival order plus expected sticky flags
    logic [7:0] q[$];
    logic       exp_ovr = 1'b0;
    logic       exp_frm = 1'b0;
    logic       exp_par = 1'b0;

    uart_rx_os #(.DEPTH(DEPTH)) dut (
        .clk(clk), .Rst(Rst), .b_tick(b_tick), .rx(rx), .rd_en(rd_en),
        .err_clr(err_clr), .rd_data(rd_data), .empty(empty), .full(full),
        .count(count), .overrun(overrun), .frame_err(frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_good);
        @(posedge clk); #1 rx = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (16) @(posedge clk);
        end
        if (PAR_EN) begin
            #1 rx = (^d) ^ ~par_good;
            repeat (16) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (16) @(posedge clk);
    endtask

    // Good frame: the model accepts the byte if there is room, else flags overrun
    task automatic send_good(input logic [7:0] d);
        send_frame(d, 1'b1, 1'b1);
        if (q.size() < DEPTH) q.push_back(d);
        else exp_ovr = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic pop_one();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        exp_ovr = 1'b0; exp_frm = 1'b0; exp_par = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++;
        if ({overrun, frame_err, parity_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {overrun, frame_err, parity_err});
        end
        checks++;
        @(posedge clk); #1 Rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single_byte();
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                repeat (STOP_CLK) @(posedge clk);
                @(negedge clk);
                if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_before_stop: got %b want 1", empty); end
                checks++;
                @(negedge clk);
                if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_stop: got %b want 0", empty); end
                checks++;
            end
        join
        q.push_back(8'hA5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (rd_data !== q[0]) begin errors++; $display("FAIL single_rd_data: got %h want %h", rd_data, q[0]); end
        checks++;
        if (count !== 4'(q.size())) begin errors++; $display("FAIL single_count: got %0d want %0d", count, q.size()); end
        checks++;
        pop_one();
        @(negedge clk);
        if (empty !== 1'b1 || count !== 4'd0) begin
            errors++; $display("FAIL single_after_pop: got empty=%b count=%0d want empty=1 count=0", empty, count);
        end
        checks++;
        pop_one();
        @(negedge clk);
        if (count !== 4'(q.size())) begin errors++; $display("FAIL pop_when_empty: got count=%0d want %0d", count, q.size()); end
        checks++;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            send_good(d);
            @(negedge clk);
            if (rd_data !== q[0]) begin errors++; $display("FAIL rand_byte_%0d: got %h want %h", k, rd_data, q[0]); end
            checks++;
            pop_one();
        end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        if (count !== 4'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL glitch_push: got count=%0d empty=%b want 0/1", count, empty);
        end
        checks++;
        if ({overrun, frame_err, parity_err} !== 3'b000) begin
            errors++; $display("FAIL glitch_flags: got %b want 000", {overrun, frame_err, parity_err});
        end
        checks++;
        d = 8'($urandom_range(0, 255));
        send_good(d);
        @(negedge clk);
        if (rd_data !== d || count !== 4'd1) begin
            errors++; $display("FAIL glitch_next_byte: got %h/%0d want %h/1", rd_data, count, d);
        end
        checks++;
        pop_one();
    endtask

    task automatic test_frame_break();
        send_frame(8'h3C, 1'b0, 1'b1);
        exp_frm = 1'b1;
        repeat (64) @(posedge clk);
        @(negedge clk);
        if (frame_err !== exp_frm) begin errors++; $display("FAIL frame_err_set: got %b want %b", frame_err, exp_frm); end
        checks++;
        if (count !== 4'(q.size())) begin errors++; $display("FAIL break_count: got %0d want %0d", count, q.size()); end
        checks++;
        @(posedge clk); #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        send_good(8'h11);
        @(negedge clk);
        if (rd_data !== 8'h11 || count !== 4'd1) begin
            errors++; $display("FAIL after_break_byte: got %h/%0d want 11/1", rd_data, count);
        end
        checks++;
        pulse_clr();
        @(negedge clk);
        if (frame_err !== exp_frm) begin errors++; $display("FAIL frame_err_clr: got %b want %b", frame_err, exp_frm); end
        checks++;
        pop_one();
    endtask

    task automatic test_overrun();
        logic [7:0] last;
        last = 8'h00;
        for (int i = 1; i <= 9; i++) send_good(8'(i));
        @(negedge clk);
        if (full !== 1'b1 || count !== 4'(DEPTH)) begin
            errors++; $display("FAIL ovr_full: got full=%b count=%0d want 1/%0d", full, count, DEPTH);
        end
        checks++;
        if (overrun !== exp_ovr) begin errors++; $display("FAIL ovr_flag: got %b want %b", overrun, exp_ovr); end
        checks++;
        if (rd_data !== q[0]) begin errors++; $display("FAIL ovr_head: got %h want %h", rd_data, q[0]); end
        checks++;
        while (q.size() > 0) begin
            @(negedge clk);
            if (rd_data !== q[0]) begin errors++; $display("FAIL ovr_drain: got %h want %h", rd_data, q[0]); end
            checks++;
            last = rd_data;
            pop_one();
        end
        if (last !== 8'h08) begin errors++; $display("FAIL ovr_last_read: got %h want 08", last); end
        checks++;
        pulse_clr();
        for (int i = 0; i < DEPTH; i++) send_good(8'($urandom_range(0, 255)));
        fork
            send_frame(8'h55, 1'b1, 1'b1);
            begin
                repeat (STOP_CLK) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk); #1 rd_en = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(8'h55);
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (overrun !== 1'b0) begin errors++; $display("FAIL full_pop_overrun: got %b want 0", overrun); end
        checks++;
        if (count !== 4'(q.size()) || full !== 1'b1) begin
            errors++; $display("FAIL full_pop_count: got %0d full=%b want %0d full=1", count, full, q.size());
        end
        checks++;
        while (q.size() > 0) begin
            @(negedge clk);
            if (rd_data !== q[0]) begin errors++; $display("FAIL full_pop_drain: got %h want %h", rd_data, q[0]); end
            checks++;
            last = rd_data;
            pop_one();
        end
        if (last !== 8'h55) begin errors++; $display("FAIL full_pop_newest: got %h want 55", last); end
        checks++;
    endtask

    task automatic test_reset_mid_frame();
        send_good(8'($urandom_range(0, 255)));
        fork
            send_frame(8'hFF, 1'b1, 1'b1);
            begin
                repeat (88) @(posedge clk);
                #1 Rst = 1'b1;
                q.delete();
                exp_ovr = 1'b0; exp_frm = 1'b0; exp_par = 1'b0;
                repeat (2) @(posedge clk);
                #1 Rst = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL mid_reset_fifo: got count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
        end
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_reset_rd_data: got %h want 00", rd_data); end
        checks++;
        send_good(8'h42);
        @(negedge clk);
        if (rd_data !== 8'h42 || count !== 4'd1) begin
            errors++; $display("FAIL mid_reset_next: got %h/%0d want 42/1", rd_data, count);
        end
        checks++;
        pop_one();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, 1'b1);
            q.push_back(d);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (count !== 4'(q.size())) begin errors++; $display("FAIL b2b_count: got %0d want %0d", count, q.size()); end
        checks++;
        while (q.size() > 0) begin
            @(negedge clk);
            if (rd_data !== q[0]) begin errors++; $display("FAIL b2b_data: got %h want %h", rd_data, q[0]); end
            checks++;
            pop_one();
        end
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        send_good(8'h07);
        @(negedge clk);
        if (rd_data !== 8'h07 || count !== 4'(q.size())) begin
            errors++; $display("FAIL parity_good: got %h/%0d want 07/%0d", rd_data, count, q.size());
        end
        checks++;
        send_frame(8'h07, 1'b1, 1'b0);
        exp_par = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (parity_err !== exp_par) begin errors++; $display("FAIL parity_err_set: got %b want %b", parity_err, exp_par); end
        checks++;
        if (count !== 4'(q.size())) begin errors++; $display("FAIL parity_drop: got %0d want %0d", count, q.size()); end
        checks++;
        pulse_clr();
        pop_one();
`else
        send_good(8'($urandom_range(0, 255)));
        @(negedge clk);
        if (parity_err !== exp_par) begin errors++; $display("FAIL parity_tied: got %b want %b", parity_err, exp_par); end
        checks++;
        pop_one();
`endif
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_break();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

16x-oversampled UART receiver with a receive FIFO. It sits directly upstream of the core's UART MMIO read path in `rv_uart_top`. It takes the serial `rx` pin and the 16x baud enable generated by the baud-clock block. Each framed byte is deserialised LSB first, framing is checked, and accepted bytes are buffered in a show-ahead FIFO that the memory controller pops on UART data-register reads.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, 2..64.

Ports:
- `clk`  in  1  system clock (`clk_50M` domain).
- `Rst`  in  1  reset, asynchronous, active-high.
- `b_tick`  in  1  one-`clk` pulse at 16x baud rate.
- `rx`  in  1  serial input, asynchronous to `clk`, idles high.
- `rd_en`  in  1  pop the FIFO head; ignored when `empty`.
- `err_clr`  in  1  clears the sticky error flags.
- `rd_data`  out  8  FIFO head byte (show-ahead); value is don't-care when `empty`.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overrun`  out  1  sticky; a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `parity_err`  out  1  sticky; parity mismatch (constant 0 when the parity feature is compiled out).

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser whose flops reset to 1. Its output `rx_s` is the only value the FSM samples.
- **FSM states:** IDLE, START, DATA, PAR (parity build only), STOP, BRK. `tick_cnt` is 4 bits; `bit_idx` is 3 bits. The FSM acts only on cycles where `b_tick` is high.
- **IDLE:** if `rx_s`==0, go to START with `tick_cnt`←0.
- **START:** if `tick_cnt`≠7, increment `tick_cnt`.
  - At `tick_cnt`==7 with `rx_s`==0: go to DATA, `tick_cnt`←0, `bit_idx`←0.
  - At `tick_cnt`==7 with `rx_s`==1: the start bit was a glitch; return to IDLE with no side effects.
- **DATA:** at `tick_cnt`==15, shift `rx_s` into `shreg` bit `bit_idx` (LSB first) and set `tick_cnt`←0. After bit 7, go to STOP (or PAR). Otherwise increment `tick_cnt`.
- **PAR:** at `tick_cnt`==15, compare `rx_s` with the even parity of `shreg`. On mismatch, latch a pending parity error. Go to STOP.
- **STOP:** at `tick_cnt`==15:
  - `rx_s`==1 and no pending parity error: push `shreg`, then go to IDLE.
  - `rx_s`==1 with a pending parity error: set `parity_err`, drop the byte, go to IDLE.
  - `rx_s`==0: set `frame_err`, drop the byte, go to BRK.
- **BRK:** wait for `rx_s`==1, then go to IDLE. This stops a held-low line (break condition) from re-triggering START.
- **FIFO push rule:** a push is accepted if `!full`, or if `full && rd_en` in the same cycle. Otherwise the byte is dropped and `overrun` is set. A dropped byte never alters FIFO contents.
- **FIFO pointers:** read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
- **Count update:** `count` is incremented by push, decremented by pop, and unchanged when both happen in the same cycle.
- **Pop when empty:** `rd_en` while `empty` is a no-op, including a same-cycle push into an empty FIFO (the pushed byte stays).
- **Sticky flags:** `err_clr` clears all sticky flags. If a set event and `err_clr` occur in the same cycle, the set wins.
- **Reset values:** FSM=IDLE, `tick_cnt`=0, `bit_idx`=0, pointers=0, `count`=0, `empty`=1, `full`=0, all error flags 0, `rd_data`=0.
- **Reset mid-frame:** `Rst` asserted mid-frame aborts the frame immediately. A partial byte is never pushed.

## Timing
- **Start-detect latency:** `rx` falling edge to `rx_s` falling edge is 2 `clk`.
- **Sampling points:** let T0 be the first `b_tick` with `rx_s`==0 in IDLE.
  - Start bit is checked on the 8th `b_tick` after T0.
  - Data bit n is sampled on tick 8+16(n+1).
  - Stop bit is sampled on tick 152, or tick 168 with parity.
- **Push visibility:** the push happens on the stop-sample cycle. `empty`, `count` and `rd_data` reflect it on the following `clk` edge.
- **Pop timing:** pop takes effect on the `clk` edge where `rd_en`=1. The next head byte appears on `rd_data` in the same registered update.
- **Flag timing:** `full`, `empty` and the error flags are registered, with no combinational path from `rx`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - frame is start + 8 data + even parity + stop; the PAR state exists;
  - `parity_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - frame is start + 8 data + stop (8N1); PAR is never entered;
  - `parity_err` is tied to 0.

## Test plan
All scenarios use `b_tick`=1 every `clk` (16 `clk`/bit) and DEPTH=8; scenarios 1–5 are 8N1.
- **Single byte:** send 8N1 byte 0xA5 -> `empty` falls 1 `clk` after the stop sample; `rd_data`=0xA5, `count`=1. Pulse `rd_en` -> `empty`=1, `count`=0.
- **Glitch:** drive `rx` low for 4 `clk`, then high -> no push, FSM back in IDLE, no error flags set.
- **Framing error / break:** send 0x3C with stop bit 0, holding `rx` low for 64 more `clk` -> `frame_err`=1, `count`=0, no further frames. Release `rx`, send 0x11 -> `rd_data`=0x11. `err_clr` -> `frame_err`=0.
- **Overrun and same-cycle pop at full:**
  - Send bytes 0x01..0x09 with no reads -> `full`=1, `count`=8, `overrun`=1, `rd_data`=0x01.
  - Pop 8 times -> the last value read is 0x08.
  - Refill to full, then pulse `rd_en` on the stop-sample cycle of a 10th byte 0x55 -> no overrun, `count` stays 8, 0x55 is the newest entry.
- **Reset mid-frame:** assert `Rst` during data bit 4 of 0xFF -> all outputs at reset values, no byte pushed. Next byte 0x42 is received correctly.
- **Parity build (`UART_RX_PARITY_EN`):**
  - 0x07 with parity bit 1 -> pushed.
  - 0x07 with parity bit 0 -> `parity_err`=1, no push.
